psram_spi_ctrl: RTL

Single-lane SPI master that sequences the external PSRAM: runs the power-up reset sequence, then serves one-byte read/write requests from the fabric through a valid/ready handshake. The block replaces hand-coded command sequencing with a request-driven controller and sits between user logic and the PSRAM pins (ce_n, sclk, mosi, miso). The SPI clock is a registered sys_clk/2, not a gated clock.

---
 rtl/psram_spi_ctrl_if.sv | 21 ++
 rtl/psram_spi_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/psram_spi_ctrl_if.sv
// Request/response bundle between user logic and the PSRAM SPI controller.
// master = user logic side, slave = controller side.
interface psram_spi_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [23:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/psram_spi_ctrl.sv
// Single-lane SPI master for the PSRAM: power-up reset sequence, then one-byte reads/writes.
// Define PSRAM_FAST_READ_EN to issue 0Bh fast reads (8 dummy bits) instead of 03h reads.
module psram_spi_ctrl #(
   parameter int INIT_WAIT = 3600
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   psram_spi_ctrl_if.slave   bus,
   output logic              init_done,
   output logic              ce_n,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso
);

   localparam int CW = $clog2(INIT_WAIT + 1);

`ifdef PSRAM_FAST_READ_EN
   localparam logic [7:0] RD_CMD  = 8'h0B;
   localparam logic [5:0] RD_BITS = 6'd48;
`else
   localparam logic [7:0] RD_CMD  = 8'h03;
   localparam logic [5:0] RD_BITS = 6'd40;
`endif
   localparam logic [7:0] WR_CMD  = 8'h02;
   localparam logic [5:0] WR_BITS = 6'd40;

   typedef enum logic [2:0] {
      S_INIT_WAIT,
      S_RST_EN,
      S_RST_GAP,
      S_RST,
      S_IDLE,
      S_SHIFT,
      S_DESEL
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          ph, ph_nx;
   logic [5:0]    bit_cnt, bit_cnt_nx;
   logic [5:0]    nbits, nbits_nx;
   logic          rd, rd_nx;
   logic          cmd99, cmd99_nx;
   logic [47:0]   sreg, sreg_nx;
   logic [7:0]    cap, cap_nx;

   logic          ce_n_q, sclk_q, mosi_q, ready_q, rsp_valid_q, init_done_q;
   logic [7:0]    rdata_q;
   logic          ce_n_d, sclk_d, mosi_d, ready_d, rsp_valid_d, init_done_d;
   logic [7:0]    rdata_d;

   logic          accept;
   logic          last_bit;
   logic          shift_nx;

   assign accept   = bus.req_valid & ready_q;
   assign last_bit = ph & (bit_cnt == nbits - 6'd1);

   // State and control register
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state       <= S_INIT_WAIT;
         cnt         <= '0;
         ph          <= 1'b0;
         bit_cnt     <= '0;
         nbits       <= '0;
         rd          <= 1'b0;
         cmd99       <= 1'b0;
         ce_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         init_done_q <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         ph          <= ph_nx;
         bit_cnt     <= bit_cnt_nx;
         nbits       <= nbits_nx;
         rd          <= rd_nx;
         cmd99       <= cmd99_nx;
         ce_n_q      <= ce_n_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         init_done_q <= init_done_d;
      end
   end

   // Frame shift register and read capture carry data only
   always_ff @(posedge sys_clk) begin
      sreg <= sreg_nx;
      cap  <= cap_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      ph_nx      = ph;
      bit_cnt_nx = bit_cnt;
      nbits_nx   = nbits;
      rd_nx      = rd;
      cmd99_nx   = cmd99;
      sreg_nx    = sreg;
      cap_nx     = cap;
      case (state)
         S_INIT_WAIT: begin
            if (cnt == CW'(INIT_WAIT - 1)) begin
               state_nx   = S_RST_EN;
               cnt_nx     = '0;
               ph_nx      = 1'b0;
               bit_cnt_nx = '0;
               nbits_nx   = 6'd8;
               sreg_nx    = {8'h66, 40'h0};
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_RST_GAP: begin
            // Two deselected cycles after each init command
            if (cnt == CW'(1)) begin
               cnt_nx = '0;
               if (cmd99) begin
                  state_nx = S_IDLE;
               end else begin
                  state_nx   = S_RST;
                  cmd99_nx   = 1'b1;
                  ph_nx      = 1'b0;
                  bit_cnt_nx = '0;
                  nbits_nx   = 6'd8;
                  sreg_nx    = {8'h99, 40'h0};
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_RST_EN, S_RST, S_SHIFT: begin
            if (!ph) begin
               // This edge raises sclk, so it is also the miso sample point
               ph_nx = 1'b1;
               if ((state == S_SHIFT) && rd && (bit_cnt >= nbits - 6'd8))
                  cap_nx = {cap[6:0], miso};
            end else if (last_bit) begin
               ph_nx    = 1'b0;
               state_nx = (state == S_SHIFT) ? S_DESEL : S_RST_GAP;
            end else begin
               ph_nx      = 1'b0;
               bit_cnt_nx = bit_cnt + 6'd1;
               sreg_nx    = {sreg[46:0], 1'b0};
            end
         end
         S_IDLE: begin
            if (accept) begin
               state_nx   = S_SHIFT;
               ph_nx      = 1'b0;
               bit_cnt_nx = '0;
               rd_nx      = ~bus.req_we;
               if (bus.req_we) begin
                  nbits_nx = WR_BITS;
                  sreg_nx  = {WR_CMD, bus.req_addr, bus.req_wdata, 8'h00};
               end else begin
                  // Trailing zeros keep mosi low through dummy and input bits
                  nbits_nx = RD_BITS;
                  sreg_nx  = {RD_CMD, bus.req_addr, 16'h0000};
               end
            end
         end
         S_DESEL: state_nx = S_IDLE;
         default: state_nx = S_INIT_WAIT;
      endcase
   end

   // Output logic: pins are registered copies of what the next state implies
   always_comb begin
      shift_nx    = (state_nx == S_RST_EN) || (state_nx == S_RST) || (state_nx == S_SHIFT);
      ce_n_d      = ~shift_nx;
      sclk_d      = shift_nx & ph_nx;
      mosi_d      = shift_nx & sreg_nx[47];
      ready_d     = (state_nx == S_IDLE);
      rsp_valid_d = (state == S_SHIFT) && rd && last_bit;
      rdata_d     = rsp_valid_d ? cap : rdata_q;
      init_done_d = init_done_q | (state_nx == S_IDLE);
   end

   assign ce_n          = ce_n_q;
   assign sclk          = sclk_q;
   assign mosi          = mosi_q;
   assign init_done     = init_done_q;
   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;

endmodule
